// File: rtl/barrel_shifter_pipe.sv
`timescale 1ns/1ps
// barrel_shifter_pipe
// Pipelined barrel shifter with one registered stage per shift-amount bit.
// Stage i shifts by 2^i when its sh_amt bit is set, so a full shift of
// 0..WIDTH-1 positions takes SHW = log2(WIDTH) cycles. Each stage carries
// its valid bit, data, the sh_amt bits not yet consumed, the mode, the
// original sign bit and a running carry. The whole pipe stalls as one unit
// when the last stage holds a result that the consumer is not taking.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   din / sh_amt / mode are valid
//   in_ready   a beat is accepted this cycle (pipe is advancing)
//   din        operand, WIDTH bits
//   sh_amt     shift distance 0..WIDTH-1, SHW bits
//   mode       00 LSL, 01 LSR, 10 ASR, 11 ROR
//   out_valid  dout / carry / zero are valid
//   out_ready  consumer takes the result
//   dout       shifted result
//   carry      last bit shifted or rotated out (0 when sh_amt = 0)
//   zero       dout == 0
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   sh_amt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } shiftMode_e;

  logic [SHW-1:0]   stageValid_q;
  logic [SHW-1:0]   stageValid_d;
  logic [SHW-1:0]   stageCarry_q;
  logic [SHW-1:0]   stageCarry_d;
  logic [WIDTH-1:0] stageData_q [SHW];
  logic [WIDTH-1:0] stageData_d [SHW];
  logic [SHW-1:0]   stageAmt_q  [SHW];
  logic [SHW-1:0]   stageAmt_d  [SHW];
  shiftMode_e       stageMode_q [SHW];
  shiftMode_e       stageMode_d [SHW];
  logic             stageSign_q [SHW];
  logic             stageSign_d [SHW];
  logic             advance;

  // Shift one word by a fixed power-of-two distance k and report the last
  // bit that left the word. For right shifts and rotates that is bit k-1 of
  // the input (for ROR it lands in the new MSB); for LSL it is bit WIDTH-k.
  // ASR fills from the original sign, not from the current MSB, so the sign
  // survives even if an earlier stage were to disturb the top bit.
  function automatic logic [WIDTH:0] shiftStage(
    input logic [WIDTH-1:0] data,
    input shiftMode_e       op,
    input logic             sign,
    input int               k
  );
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] fillMask;
    logic [WIDTH-1:0] lowOut;
    logic [WIDTH-1:0] highOut;
    logic             carryOut;
    fillMask = ~({WIDTH{1'b1}} >> k);
    lowOut   = data >> (k - 1);
    highOut  = data >> (WIDTH - k);
    res      = data;
    case (op)
      MODE_LSL: res = data << k;
      MODE_LSR: res = data >> k;
      MODE_ASR: res = (data >> k) | (sign ? fillMask : '0);
      MODE_ROR: res = (data >> k) | (data << (WIDTH - k));
      default:  res = data;
    endcase
    carryOut = (op == MODE_LSL) ? highOut[0] : lowOut[0];
    return {carryOut, res};
  endfunction

  // The stall is global: the pipe moves only when the last stage is empty
  // or its result is being taken, and only then can a new beat enter.
  always_comb begin
    out_valid = stageValid_q[SHW-1];
    advance   = !out_valid || out_ready;
    in_ready  = advance;
    dout      = stageData_q[SHW-1];
    carry     = stageCarry_q[SHW-1];
    zero      = (stageData_q[SHW-1] == '0);
  end

  // Next-state for every stage. Stage 0 draws from the input ports with a
  // zero incoming carry; stage s draws from stage s-1. A stage whose sh_amt
  // bit is clear passes data and carry through untouched. The consumed amt
  // bit is cleared so each register holds only the bits still to be used.
  always_comb begin
    logic             srcValid;
    logic [WIDTH-1:0] srcData;
    logic             srcCarry;
    logic [SHW-1:0]   srcAmt;
    shiftMode_e       srcMode;
    logic             srcSign;
    logic [WIDTH:0]   shifted;
    stageValid_d = stageValid_q;
    stageCarry_d = stageCarry_q;
    stageData_d  = stageData_q;
    stageAmt_d   = stageAmt_q;
    stageMode_d  = stageMode_q;
    stageSign_d  = stageSign_q;
    srcValid     = 1'b0;
    srcData      = '0;
    srcCarry     = 1'b0;
    srcAmt       = '0;
    srcMode      = MODE_LSL;
    srcSign      = 1'b0;
    shifted      = '0;
    for (int s = 0; s < SHW; s++) begin
      if (s == 0) begin
        srcValid = in_valid;
        srcData  = din;
        srcCarry = 1'b0;
        srcAmt   = sh_amt;
        srcMode  = shiftMode_e'(mode);
        srcSign  = din[WIDTH-1];
      end else begin
        srcValid = stageValid_q[s-1];
        srcData  = stageData_q[s-1];
        srcCarry = stageCarry_q[s-1];
        srcAmt   = stageAmt_q[s-1];
        srcMode  = stageMode_q[s-1];
        srcSign  = stageSign_q[s-1];
      end
      shifted = shiftStage(srcData, srcMode, srcSign, 1 << s);
      stageValid_d[s] = srcValid;
      if (srcAmt[s]) begin
        stageData_d[s]  = shifted[WIDTH-1:0];
        stageCarry_d[s] = shifted[WIDTH];
      end else begin
        stageData_d[s]  = srcData;
        stageCarry_d[s] = srcCarry;
      end
      stageAmt_d[s]  = srcAmt & ~(SHW'(1) << s);
      stageMode_d[s] = srcMode;
      stageSign_d[s] = srcSign;
    end
  end

  // Stage registers. Reset wins over everything, including a beat presented
  // on the reset edge, and wipes all in-flight beats. Otherwise every stage
  // moves together on advance and holds together on a stall, which keeps the
  // presented result stable and preserves order.
  always_ff @(posedge clk) begin
    if (rst) begin
      stageValid_q <= '0;
      stageCarry_q <= '0;
      for (int s = 0; s < SHW; s++) begin
        stageData_q[s] <= '0;
        stageAmt_q[s]  <= '0;
        stageMode_q[s] <= MODE_LSL;
        stageSign_q[s] <= 1'b0;
      end
    end else if (advance) begin
      stageValid_q <= stageValid_d;
      stageCarry_q <= stageCarry_d;
      stageData_q  <= stageData_d;
      stageAmt_q   <= stageAmt_d;
      stageMode_q  <= stageMode_d;
      stageSign_q  <= stageSign_d;
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
`timescale 1ns/1ps
// tb_barrel_shifter_pipe
// Directed and random stimulus for barrel_shifter_pipe at WIDTH = 8.
module tb_barrel_shifter_pipe;

  localparam int WIDTH = 8;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic [2:0] sh_amt;
  logic [1:0] mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       carry;
  logic       zero;

  int         checkCount;
  int         errorCount;
  int         received;
  int         sent;
  logic [8:0] expQ [$];

  barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .sh_amt    (sh_amt),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .carry     (carry),
    .zero      (zero)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: shift one bit at a time, remembering the bit that
  // leaves the word last. Returns {carry, dout}.
  function automatic logic [8:0] refShift(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m);
    logic [7:0] r;
    logic       c;
    r = d;
    c = 1'b0;
    for (int j = 0; j < int'(a); j++) begin
      case (m)
        2'b00: begin c = r[7]; r = {r[6:0], 1'b0}; end
        2'b01: begin c = r[0]; r = {1'b0, r[7:1]}; end
        2'b10: begin c = r[0]; r = {r[7], r[7:1]}; end
        default: begin c = r[0]; r = {r[0], r[7:1]}; end
      endcase
    end
    return {c, r};
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive all DUT inputs at once.
  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [7:0] d,
                               input logic [2:0] a, input logic rdy);
    in_valid  = v;
    mode      = m;
    din       = d;
    sh_amt    = a;
    out_ready = rdy;
  endtask

  // One clock cycle against the scoreboard: check the presented result
  // against the oldest expected one, retire it if taken, record a newly
  // accepted beat, then advance past the next rising edge.
  task automatic stepCycle(input string tag, output logic accepted);
    logic [8:0] e;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid) begin
      if (expQ.size() == 0) begin
        checkOutput({tag, " unexpected out_valid"}, {31'b0, out_valid}, 32'd0);
      end else begin
        e = expQ[0];
        checkOutput({tag, " dout"}, {24'b0, dout}, {24'b0, e[7:0]});
        checkOutput({tag, " carry"}, {31'b0, carry}, {31'b0, e[8]});
        checkOutput({tag, " zero"}, {31'b0, zero}, {31'b0, (e[7:0] == 8'h00)});
        if (out_ready) begin
          expQ.delete(0);
          received++;
        end
      end
    end
    if (accepted) expQ.push_back(refShift(din, sh_amt, mode));
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty pipe with out_ready high; expected values are
  // hand-computed. Latency counts edges from acceptance to out_valid.
  task automatic runDirected(input string tag, input logic [1:0] m, input logic [7:0] d,
                             input logic [2:0] a, input logic [7:0] expD, input logic expC);
    int lat;
    applyStimulus(1'b1, m, d, a, 1'b1);
    #1;
    checkOutput({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 2'b00, 8'h00, 3'd0, 1'b1);
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput({tag, " latency"}, lat, 32'd3);
    checkOutput({tag, " dout"}, {24'b0, dout}, {24'b0, expD});
    checkOutput({tag, " carry"}, {31'b0, carry}, {31'b0, expC});
    checkOutput({tag, " zero"}, {31'b0, zero}, {31'b0, (expD == 8'h00)});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Outputs expected right after a reset edge.
  task automatic checkResetState(input string tag);
    checkOutput({tag, " out_valid"}, {31'b0, out_valid}, 32'd0);
    checkOutput({tag, " dout"}, {24'b0, dout}, 32'd0);
    checkOutput({tag, " carry"}, {31'b0, carry}, 32'd0);
    checkOutput({tag, " zero"}, {31'b0, zero}, 32'd1);
    checkOutput({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  // Main sequence: reset, directed vectors, stalled stream, mid-flight
  // reset, then the long random run with a drain at the end.
  initial begin
    logic acc;
    int   idx;
    checkCount = 0;
    errorCount = 0;
    received   = 0;
    sent       = 0;
    rst        = 1'b1;
    applyStimulus(1'b0, 2'b00, 8'h00, 3'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkResetState("reset");

    runDirected("ASR 90>>3", 2'b10, 8'h90, 3'd3, 8'hF2, 1'b0);
    runDirected("LSL 81<<1", 2'b00, 8'h81, 3'd1, 8'h02, 1'b1);
    runDirected("LSL 80<<1", 2'b00, 8'h80, 3'd1, 8'h00, 1'b1);
    runDirected("ROR 01 1", 2'b11, 8'h01, 3'd1, 8'h80, 1'b1);
    runDirected("LSR FF>>7", 2'b01, 8'hFF, 3'd7, 8'h01, 1'b1);
    runDirected("ROR A5 0", 2'b11, 8'hA5, 3'd0, 8'hA5, 1'b0);
    runDirected("ASR 3C 0", 2'b10, 8'h3C, 3'd0, 8'h3C, 1'b0);
    runDirected("ROR 0E 3", 2'b11, 8'h0E, 3'd3, 8'hC1, 1'b1);
    runDirected("ASR 40>>7", 2'b10, 8'h40, 3'd7, 8'h00, 1'b1);

    // Ten back-to-back beats with the consumer stalled for cycles 4-8.
    expQ.delete();
    received = 0;
    sent     = 0;
    for (int c = 0; c < 60 && received < 10; c++) begin
      idx = (sent < 10) ? sent : 0;
      applyStimulus(sent < 10, 2'(idx % 4), 8'(8'h1D * idx + 8'h87), 3'(idx * 3 + 1),
                    !(c >= 4 && c <= 8));
      #1;
      if (c >= 4 && c <= 8) checkOutput("stall in_ready", {31'b0, in_ready}, 32'd0);
      stepCycle("stream", acc);
      if (acc) sent++;
    end
    checkOutput("stream sent", sent, 32'd10);
    checkOutput("stream received", received, 32'd10);
    checkOutput("stream leftover", expQ.size(), 32'd0);

    // Two beats in flight, then reset before either leaves; a beat offered
    // on the reset edge must be ignored as well.
    applyStimulus(1'b1, 2'b00, 8'h11, 3'd1, 1'b1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b11, 8'h22, 3'd2, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(1'b1, 2'b01, 8'h33, 3'd1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 8'h00, 3'd0, 1'b1);
    checkResetState("mid reset");
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checkOutput("post-reset out_valid", {31'b0, out_valid}, 32'd0);
    end
    runDirected("after reset LSL 0F<<4", 2'b00, 8'h0F, 3'd4, 8'hF0, 1'b0);

    // Random traffic with random backpressure against the model.
    expQ.delete();
    received = 0;
    sent     = 0;
    for (int c = 0; c < 60000 && sent < 10000; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
                    3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
      stepCycle("random", acc);
      if (acc) sent++;
    end
    for (int c = 0; c < 50 && expQ.size() > 0; c++) begin
      applyStimulus(1'b0, 2'b00, 8'h00, 3'd0, 1'b1);
      stepCycle("drain", acc);
    end
    checkOutput("random sent", sent, 32'd10000);
    checkOutput("random received", received, 32'd10000);
    checkOutput("random leftover", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
